// File: rtl/alu_mdu.sv
// EX-stage ALU with registered result/flags and an iterative multiply/divide unit.
// Single-cycle ops return next cycle; MULT/DIV run WIDTH iterations with busy held high.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SAW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SAW-1:0]   sa,
    output logic [WIDTH-1:0] C,
    output logic             valid,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             big,
    output logic             smal
);
    localparam logic [3:0] OP_SUB  = 4'b0000, OP_OR    = 4'b0001, OP_ADD  = 4'b0010, OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100, OP_SRL   = 4'b0101, OP_SRA  = 4'b0110, OP_SRAV = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000, OP_AND   = 4'b1001, OP_XOR  = 4'b1010, OP_MULTU = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1100, OP_DIV   = 4'b1101, OP_DIVU = 4'b1110, OP_MTHL = 4'b1111;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t state;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opd;
    logic [SAW-1:0]     cnt;
    logic               neg_q, neg_r;
    logic               zero_l, big_l, smal_l;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               md_signed, b_is_zero, last_iter;
    logic               a_eq_b, a_gt_b, a_lt_b;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

    assign a_s       = A;
    assign b_s       = B;
    assign a_eq_b    = (A == B);
    assign a_gt_b    = (a_s > b_s);
    assign a_lt_b    = (a_s < b_s);
    assign md_signed = (ALUop == OP_MULT) || (ALUop == OP_DIV);
    assign b_is_zero = (B == '0);
    assign last_iter = (cnt == SAW'(WIDTH - 1));

    always_comb begin
        alu_res = '0;
        case (ALUop)
            OP_SUB:  alu_res = A - B;
            OP_OR:   alu_res = A | B;
            OP_ADD:  alu_res = A + B;
            OP_SLTU: alu_res = WIDTH'(A < B);
            OP_SLL:  alu_res = B << sa;
            OP_SRL:  alu_res = B >> sa;
            OP_SRA:  alu_res = b_s >>> sa;
            OP_SRAV: alu_res = b_s >>> A[SAW-1:0];
            OP_AND:  alu_res = A & B;
            OP_XOR:  alu_res = A ^ B;
            OP_SLT:  alu_res = WIDTH'(a_lt_b);
            OP_MTHL: alu_res = B;
            default: alu_res = '0;
        endcase
    end

    // Shared iteration register: multiply keeps {partial, multiplier}, divide keeps {remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opd};
    assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign prod_fix  = neg_q ? -mul_next : mul_next;
    assign quo_fix   = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    assign rem_fix   = neg_r ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
            C     <= '0;
            hi    <= '0;
            lo    <= '0;
            zero  <= 1'b0;
            big   <= 1'b0;
            smal  <= 1'b0;
            cnt   <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    zero_l <= a_eq_b;
                    big_l  <= a_gt_b;
                    smal_l <= a_lt_b;
                    case (ALUop)
                        OP_MULT, OP_MULTU: begin
                            acc   <= {{WIDTH{1'b0}}, magnitude(B, md_signed)};
                            opd   <= magnitude(A, md_signed);
                            neg_q <= md_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b_is_zero) begin
                                hi    <= A;
                                lo    <= '1;
                                C     <= '1;
                                valid <= 1'b1;
                                zero  <= a_eq_b;
                                big   <= a_gt_b;
                                smal  <= a_lt_b;
                            end else begin
                                acc   <= {{WIDTH{1'b0}}, magnitude(A, md_signed)};
                                opd   <= magnitude(B, md_signed);
                                neg_q <= md_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                                neg_r <= md_signed & A[WIDTH-1];
                                cnt   <= '0;
                                busy  <= 1'b1;
                                state <= DIV;
                            end
                        end
                        default: begin
                            if (ALUop == OP_MTHL) begin
                                hi <= A;
                                lo <= B;
                            end
                            C     <= alu_res;
                            valid <= 1'b1;
                            zero  <= a_eq_b;
                            big   <= a_gt_b;
                            smal  <= a_lt_b;
                        end
                    endcase
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        {hi, lo} <= prod_fix;
                        C        <= prod_fix[WIDTH-1:0];
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                        zero     <= zero_l;
                        big      <= big_l;
                        smal     <= smal_l;
                        state    <= IDLE;
                    end
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        lo    <= quo_fix;
                        hi    <= rem_fix;
                        C     <= quo_fix;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        zero  <= zero_l;
                        big   <= big_l;
                        smal  <= smal_l;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: a 32-bit and a 16-bit instance checked against an arithmetic reference model.
module tb_alu_mdu;
    logic        clk = 1'b0;
    logic        reset, start, sel16;
    logic [3:0]  ALUop;
    logic [31:0] A, B;
    logic [4:0]  sa;
    logic        start32, start16;

    logic [31:0] C32, hi32, lo32;
    logic        v32, b32, z32, g32, s32;
    logic [15:0] C16, hi16, lo16;
    logic        v16, b16, z16, g16, s16;

    logic [31:0] c_o, hi_o, lo_o;
    logic        v_o, b_o, z_o, g_o, s_o;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] ehi[2];
    logic [31:0] elo[2];

    assign start32 = start & ~sel16;
    assign start16 = start & sel16;

    alu_mdu #(.WIDTH(32), .SAW(5)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .ALUop(ALUop), .A(A), .B(B), .sa(sa),
        .C(C32), .valid(v32), .busy(b32), .hi(hi32), .lo(lo32), .zero(z32), .big(g32), .smal(s32)
    );

    alu_mdu #(.WIDTH(16), .SAW(4)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .ALUop(ALUop), .A(A[15:0]), .B(B[15:0]), .sa(sa[3:0]),
        .C(C16), .valid(v16), .busy(b16), .hi(hi16), .lo(lo16), .zero(z16), .big(g16), .smal(s16)
    );

    assign c_o  = sel16 ? {16'h0, C16}  : C32;
    assign hi_o = sel16 ? {16'h0, hi16} : hi32;
    assign lo_o = sel16 ? {16'h0, lo16} : lo32;
    assign v_o  = sel16 ? v16 : v32;
    assign b_o  = sel16 ? b16 : b32;
    assign z_o  = sel16 ? z16 : z32;
    assign g_o  = sel16 ? g16 : g32;
    assign s_o  = sel16 ? s16 : s32;

    always #5 clk = ~clk;

    function automatic longint sx(input logic [63:0] v, input int w);
        longint t;
        t = longint'(v << (64 - w));
        return t >>> (64 - w);
    endfunction

    function automatic logic [63:0] mask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] s);
        longint x, y;
        x = sx({32'h0, a}, 32);
        y = sx({32'h0, b}, 32);
        case (op)
            4'd0:  return a - b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return (a < b) ? 32'd1 : 32'd0;
            4'd4:  return b << s;
            4'd5:  return b >> s;
            4'd6:  return 32'(y >>> s);
            4'd7:  return 32'(y >>> a[4:0]);
            4'd9:  return a & b;
            4'd10: return a ^ b;
            4'd12: return (x < y) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b, input int w);
        longint x, y;
        x = sx({32'h0, a}, w);
        y = sx({32'h0, b}, w);
        return {x == y, x > y, x < y};
    endfunction

    task automatic ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int w,
                          output logic [31:0] xh, output logic [31:0] xl);
        logic [63:0] m, up, a64, b64;
        longint p, q, r;
        m = mask(w);
        a64 = {32'h0, a};
        b64 = {32'h0, b};
        xh = 32'h0;
        xl = 32'h0;
        if (op == 4'd8) begin
            p = sx(a64, w) * sx(b64, w);
            xh = 32'(64'(p >>> w) & m);
            xl = 32'(64'(p) & m);
        end else if (op == 4'd11) begin
            up = a64 * b64;
            xh = 32'((up >> w) & m);
            xl = 32'(up & m);
        end else if (b64 == 64'h0) begin
            xh = a;
            xl = 32'(m);
        end else if (op == 4'd13) begin
            q = sx(a64, w) / sx(b64, w);
            r = sx(a64, w) % sx(b64, w);
            xl = 32'(64'(q) & m);
            xh = 32'(64'(r) & m);
        end else begin
            xl = 32'(a64 / b64);
            xh = 32'(a64 % b64);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
        ALUop = op; A = a; B = b; sa = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        sel16 = 1'b0; reset = 1'b1; start = 1'b1; ALUop = 4'd2; A = 32'd5; B = 32'd5; sa = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({C32, hi32, lo32, v32, b32, z32, g32, s32} !== 101'h0) begin
            n_fail++;
            $display("FAIL reset32: got C=%h hi=%h lo=%h v=%b busy=%b z=%b expected all zero", C32, hi32, lo32, v32, b32, z32);
        end
        n_chk++;
        if ({C16, hi16, lo16, v16, b16, z16, g16, s16} !== 53'h0) begin
            n_fail++;
            $display("FAIL reset16: got C=%h hi=%h lo=%h v=%b busy=%b expected all zero", C16, hi16, lo16, v16, b16);
        end
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        ehi = '{32'h0, 32'h0};
        elo = '{32'h0, 32'h0};
    endtask

    task automatic test_add;
        sel16 = 1'b0;
        issue(4'd2, 32'd7, 32'hFFFF_FFFD, 5'd0);
        n_chk++;
        if ({v_o, c_o, z_o, g_o, s_o} !== {1'b1, 32'd4, 3'b010}) begin
            n_fail++;
            $display("FAIL add_first: got v=%b C=%h zgs=%b%b%b expected v=1 C=4 zgs=010", v_o, c_o, z_o, g_o, s_o);
        end
        @(posedge clk); #1;
        n_chk++;
        if (v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL add_valid_drop: got valid=%b expected 0", v_o);
        end
    endtask

    task automatic test_single_ops;
        logic [3:0]  dop[4] = '{4'd6, 4'd7, 4'd3, 4'd12};
        logic [31:0] da[4]  = '{32'd0, 32'd33, 32'd1, 32'd1};
        logic [31:0] db[4]  = '{32'h8000_0000, 32'hF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [4:0]  ds[4]  = '{5'd4, 5'd0, 5'd0, 5'd0};
        logic [31:0] dexp[4] = '{32'hF800_0000, 32'h78, 32'd1, 32'd0};
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  s;
        sel16 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(dop[i], da[i], db[i], ds[i]);
            n_chk++;
            if (v_o !== 1'b1 || c_o !== dexp[i]) begin
                n_fail++;
                $display("FAIL directed_op%0d: got v=%b C=%h expected v=1 C=%h", dop[i], v_o, c_o, dexp[i]);
            end
        end
        for (int i = 0; i < 60; i++) begin
            do op = 4'($urandom_range(0, 15)); while (op inside {4'd8, 4'd11, 4'd13, 4'd14, 4'd15});
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            s = 5'($urandom);
            issue(op, a, b, s);
            n_chk++;
            if ({v_o, c_o, z_o, g_o, s_o} !== {1'b1, ref_alu(op, a, b, s), ref_flags(a, b, 32)}
                || hi_o !== ehi[0] || lo_o !== elo[0]) begin
                n_fail++;
                $display("FAIL rand_op%0d a=%h b=%h sa=%0d: got v=%b C=%h zgs=%b%b%b hi=%h lo=%h expected C=%h zgs=%b hi=%h lo=%h",
                         op, a, b, s, v_o, c_o, z_o, g_o, s_o, hi_o, lo_o, ref_alu(op, a, b, s), ref_flags(a, b, 32), ehi[0], elo[0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  s;
        sel16 = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do op = 4'($urandom_range(0, 12)); while (op inside {4'd8, 4'd11});
            a = $urandom; b = $urandom; s = 5'($urandom);
            ALUop = op; A = a; B = b; sa = s;
            @(posedge clk); #1;
            n_chk++;
            if (v_o !== 1'b1 || c_o !== ref_alu(op, a, b, s)) begin
                n_fail++;
                $display("FAIL b2b_%0d op%0d: got v=%b C=%h expected v=1 C=%h", i, op, v_o, c_o, ref_alu(op, a, b, s));
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got valid=%b expected 0", v_o);
        end
    endtask

    task automatic test_mthl;
        sel16 = 1'b0;
        issue(4'd15, 32'd1, 32'd2, 5'd0);
        n_chk++;
        if (v_o !== 1'b1 || hi_o !== 32'd1 || lo_o !== 32'd2) begin
            n_fail++;
            $display("FAIL mthl: got v=%b hi=%h lo=%h expected v=1 hi=1 lo=2", v_o, hi_o, lo_o);
        end
        ehi[0] = 32'd1;
        elo[0] = 32'd2;
    endtask

    task automatic test_muldiv(input bit w16);
        logic [3:0]  dop[7] = '{4'd8, 4'd11, 4'd13, 4'd14, 4'd13, 4'd14, 4'd13};
        logic [31:0] da[7]  = '{32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'd5, 32'd9, 32'd0};
        logic [31:0] db[7]  = '{32'd7, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};
        int          w;
        logic [31:0] m, a, b, xh, xl;
        logic [3:0]  op;
        logic [2:0]  xf;
        bit          bad;
        sel16 = w16;
        w = w16 ? 16 : 32;
        m = w16 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        da[6] = 32'd1 << (w - 1);
        for (int i = 0; i < 15; i++) begin
            if (i < 7) begin
                op = dop[i]; a = da[i] & m; b = db[i] & m;
            end else begin
                op = (i % 2 == 0) ? 4'($urandom_range(13, 14)) : (($urandom_range(0, 1) == 0) ? 4'd8 : 4'd11);
                a = $urandom & m; b = $urandom & m;
            end
            ref_md(op, a, b, w, xh, xl);
            xf = ref_flags(a, b, w);
            issue(op, a, b, 5'($urandom));
            ALUop = 4'($urandom); A = $urandom; B = $urandom;
            if ((op == 4'd13 || op == 4'd14) && b == 32'h0) begin
                n_chk++;
                if (v_o !== 1'b1 || b_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL w%0d_divzero_timing a=%h: got v=%b busy=%b expected v=1 busy=0", w, a, v_o, b_o);
                end
            end else begin
                bad = (b_o !== 1'b1) || (v_o !== 1'b0);
                for (int k = 1; k < w; k++) begin
                    @(posedge clk); #1;
                    if (b_o !== 1'b1 || v_o !== 1'b0) bad = 1'b1;
                end
                n_chk++;
                if (bad) begin
                    n_fail++;
                    $display("FAIL w%0d_busy_window op%0d: busy/valid wrong during %0d iteration cycles", w, op, w);
                end
                @(posedge clk); #1;
                n_chk++;
                if (v_o !== 1'b1 || b_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL w%0d_done_timing op%0d: got v=%b busy=%b expected v=1 busy=0", w, op, v_o, b_o);
                end
            end
            n_chk++;
            if (hi_o !== xh || lo_o !== xl || c_o !== xl || {z_o, g_o, s_o} !== xf) begin
                n_fail++;
                $display("FAIL w%0d_md_op%0d a=%h b=%h: got hi=%h lo=%h C=%h zgs=%b%b%b expected hi=%h lo=%h C=%h zgs=%b",
                         w, op, a, b, hi_o, lo_o, c_o, z_o, g_o, s_o, xh, xl, xl, xf);
            end
            ehi[w16] = xh;
            elo[w16] = xl;
            @(posedge clk); #1;
        end
        sel16 = 1'b0;
    endtask

    task automatic test_busy_ignore;
        logic [31:0] a, b, xh, xl;
        bit          bad;
        sel16 = 1'b0;
        a = $urandom; b = $urandom;
        ref_md(4'd8, a, b, 32, xh, xl);
        issue(4'd8, a, b, 5'd0);
        bad = 1'b0;
        for (int k = 1; k < 32; k++) begin
            if (k >= 3 && k < 8) begin
                ALUop = 4'd2; A = 32'd1; B = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (v_o !== 1'b0 || b_o !== 1'b1) bad = 1'b1;
        end
        start = 1'b0;
        n_chk++;
        if (bad) begin
            n_fail++;
            $display("FAIL ignore_busy_window: valid/busy disturbed by start during busy");
        end
        @(posedge clk); #1;
        n_chk++;
        if (v_o !== 1'b1 || hi_o !== xh || lo_o !== xl || c_o !== xl) begin
            n_fail++;
            $display("FAIL ignore_result: got v=%b hi=%h lo=%h C=%h expected v=1 hi=%h lo=%h C=%h", v_o, hi_o, lo_o, c_o, xh, xl, xl);
        end
        ehi[0] = xh;
        elo[0] = xl;
        issue(4'd2, 32'd10, 32'd20, 5'd0);
        n_chk++;
        if (v_o !== 1'b1 || c_o !== 32'd30 || hi_o !== xh) begin
            n_fail++;
            $display("FAIL resample_after_busy: got v=%b C=%h hi=%h expected v=1 C=0000001e hi=%h", v_o, c_o, hi_o, xh);
        end
    endtask

    task automatic test_reset_abort;
        bit seen;
        sel16 = 1'b0;
        issue(4'd8, 32'd1234, 32'd5678, 5'd0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_chk++;
        if (b_o !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0 || c_o !== 32'h0 || v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b hi=%h lo=%h C=%h v=%b expected all zero", b_o, hi_o, lo_o, c_o, v_o);
        end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (v_o !== 1'b0 || b_o !== 1'b0) seen = 1'b1;
        end
        n_chk++;
        if (seen) begin
            n_fail++;
            $display("FAIL abort_no_valid: valid or busy rose after aborted op");
        end
        ehi = '{32'h0, 32'h0};
        elo = '{32'h0, 32'h0};
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sel16 = 1'b0; ALUop = 4'd0; A = 32'h0; B = 32'h0; sa = 5'd0;
        test_reset;
        test_add;
        test_single_ops;
        test_back_to_back;
        test_mthl;
        test_muldiv(1'b0);
        test_muldiv(1'b1);
        test_busy_ignore;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
